// File: rtl/out_buffer_pkg.sv
// out_buffer_pkg
//   Shared types and constants for the CPU OUT-instruction display buffer.
//   DATA_W   : width of a displayed value
//   state_t  : display FSM states; ST_BLANK keeps its encoding even when the
//              blanking feature (OUT_BUFFER_BLANK_EN) is compiled out
//   min_width: bit width able to hold n-1, never less than 1
package out_buffer_pkg;

    localparam int DATA_W = 33;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_BLANK = 2'b10
    } state_t;

    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_buffer_if.sv
// out_buffer_if
//   Bundles the CPU write handshake, the flush input and the display-side
//   outputs of out_buffer.
//   master : drives wr_valid/wr_data/clear, observes everything else (CPU side)
//   slave  : the buffer itself
//   wr_valid, wr_data, wr_ready : OUT write handshake
//   clear                       : synchronous flush of buffer and display
//   disp_value, cu_showDisplay  : value and enable for the BCD/7-seg stage
//   fifo_count                  : entries currently buffered
interface out_buffer_if
    import out_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clear;
    logic [DATA_W-1:0] disp_value;
    logic              cu_showDisplay;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output wr_valid, wr_data, clear,
        input  wr_ready, disp_value, cu_showDisplay, fifo_count
    );

    modport slave (
        input  wr_valid, wr_data, clear,
        output wr_ready, disp_value, cu_showDisplay, fifo_count
    );

endinterface

// File: rtl/out_buffer_fifo.sv
// out_buffer_fifo
//   DEPTH-entry synchronous FIFO holding values waiting for the display.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous flush; wins over push and pop
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_data     : head entry
//   o_count    : number of entries held (0..DEPTH)
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
module out_buffer_fifo
    import out_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign w_push = i_push && !o_full  && !i_clear;
    assign w_pop  = i_pop  && !o_empty && !i_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap onto valid slots by themselves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/out_buffer.sv
// out_buffer
//   Buffers CPU OUT-instruction values and paces them onto the display so each
//   one stays visible for at least HOLD_CYCLES clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : out_buffer_if.slave (write handshake, clear, display outputs)
//   Parameters : DEPTH (power of two >= 2), HOLD_CYCLES (>= 2),
//                BLANK_CYCLES (>= 1, only used with OUT_BUFFER_BLANK_EN)
//   Build option: define OUT_BUFFER_BLANK_EN to insert a display-off gap of
//   BLANK_CYCLES clocks between consecutive backlogged values.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | nothing shown; pops the head as soon as the FIFO is non-empty
//   ST_HOLD  | value shown; hold timer counts down and rests at 0
//   ST_BLANK | display off between two values (OUT_BUFFER_BLANK_EN only)
module out_buffer
    import out_buffer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    out_buffer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
`ifdef OUT_BUFFER_BLANK_EN
    localparam int BLK_W = min_width(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(BLANK_CYCLES - 1);
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("out_buffer: DEPTH must be a power of two and at least 2");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("out_buffer: HOLD_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("out_buffer: BLANK_CYCLES must be at least 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic [DATA_W-1:0] r_disp;
    logic [DATA_W-1:0] w_disp_nxt;
    logic              r_show;
    logic              w_show_nxt;
`ifdef OUT_BUFFER_BLANK_EN
    logic [BLK_W-1:0]  r_blank;
    logic [BLK_W-1:0]  w_blank_nxt;
`endif

    logic              w_wr_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;

    // Ready comes only from registered occupancy and the clear input, so it
    // never depends on this cycle's pop decision.
    assign w_wr_ready = !w_full && !bus.clear;
    assign w_push     = bus.wr_valid && w_wr_ready;

    out_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (bus.clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.wr_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.wr_ready       = w_wr_ready;
    assign bus.disp_value     = r_disp;
    assign bus.cu_showDisplay = r_show;
    assign bus.fifo_count     = w_count;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_disp_nxt  = r_disp;
        w_show_nxt  = r_show;
        w_pop       = 1'b0;
`ifdef OUT_BUFFER_BLANK_EN
        w_blank_nxt = r_blank;
`endif
        if (bus.clear) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_disp_nxt  = '0;
            w_show_nxt  = 1'b0;
`ifdef OUT_BUFFER_BLANK_EN
            w_blank_nxt = '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_disp_nxt  = w_head;
                        w_show_nxt  = 1'b1;
                        w_timer_nxt = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Timer rests at 0; with nothing queued the last value stays up.
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - 1'b1;
                    end else if (!w_empty) begin
`ifdef OUT_BUFFER_BLANK_EN
                        w_show_nxt  = 1'b0;
                        w_blank_nxt = BLANK_LOAD;
                        w_state_nxt = ST_BLANK;
`else
                        w_pop       = 1'b1;
                        w_disp_nxt  = w_head;
                        w_timer_nxt = HOLD_LOAD;
`endif
                    end
                end
`ifdef OUT_BUFFER_BLANK_EN
                ST_BLANK: begin
                    // Only the FSM pops and clear is handled above, so the
                    // FIFO is still non-empty when the gap ends.
                    if (r_blank != '0) begin
                        w_blank_nxt = r_blank - 1'b1;
                    end else begin
                        w_pop       = 1'b1;
                        w_disp_nxt  = w_head;
                        w_show_nxt  = 1'b1;
                        w_timer_nxt = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                    w_disp_nxt  = '0;
                    w_show_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_disp  <= '0;
            r_show  <= 1'b0;
`ifdef OUT_BUFFER_BLANK_EN
            r_blank <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_disp  <= w_disp_nxt;
            r_show  <= w_show_nxt;
`ifdef OUT_BUFFER_BLANK_EN
            r_blank <= w_blank_nxt;
`endif
        end
    end

endmodule
